aes_arbiter: RTL
================

AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 Parameter AES_LEN, default 128: block, key and result width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5: key ROM address width.
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 nrst  in  1: reset, asynchronous, active-low.
REQ-005 req0, req1  in  1 each: level request per requester; held high until that requester's done pulse.
REQ-006 key_addr0, key_addr1  in  ADDR_WIDTH each: key ROM address per requester; sampled at grant.
REQ-007 block0, block1  in  AES_LEN each: plaintext per requester; sampled at grant.
REQ-008 flush  in  1: invalidates the expanded-key cache (ROM contents changed).
REQ-009 done0, done1  out  1 each: one-cycle completion pulse to the owning requester.
REQ-010 result  out  AES_LEN: last ciphertext; held until the next completion.
REQ-011 busy  out  1: high in every state except IDLE.
REQ-012 core_init, core_next  out  1 each: one-cycle command pulses to the AES core.
REQ-013 core_ready, core_valid  in  1 each: AES core ready and result_valid.
REQ-014 core_block  out  AES_LEN: registered plaintext of the granted request.
REQ-015 core_result  in  AES_LEN: AES core result bus.
REQ-016 key_en  out  1, key_rom_addr  out  ADDR_WIDTH: key ROM read enable and address; ROM data valid one cycle after key_en.

Function
REQ-017 States SHALL be IDLE, KEY_RD, INIT, WAIT_INIT, NEXT, WAIT_NEXT, DONE; encryption only.
REQ-018 IDLE: if any req high, grant per round-robin pointer, latch owner, block and key address, then go to NEXT on cache hit, else KEY_RD.
REQ-019 Both req high in IDLE: grant the requester named by the pointer; the pointer SHALL move to the other requester after each DONE.
REQ-020 Only one req high: grant it regardless of pointer; pointer still updates at DONE.
REQ-021 Cache hit: cache_valid=1 and latched key address equals cached_addr.
REQ-022 KEY_RD: key_en=1 for exactly one cycle with key_rom_addr = latched address; next state INIT.
REQ-023 INIT: core_init=1 for one cycle; next state WAIT_INIT.
REQ-024 WAIT_INIT: stay until core_ready=1; then set cache_valid=1, cached_addr=latched address, go to NEXT.
REQ-025 NEXT: core_next=1 for one cycle; next state WAIT_NEXT.
REQ-026 WAIT_NEXT: stay until core_ready=1 and core_valid=1; then capture core_result into result, go to DONE.
REQ-027 DONE: pulse done of the owner only, one cycle; go to IDLE; a new grant is possible the following cycle.
REQ-028 core_block and key_rom_addr SHALL remain stable from grant through DONE.
REQ-029 Request deasserted mid-operation: the operation SHALL complete and done still pulses.
REQ-030 flush SHALL clear cache_valid in any state; flush during WAIT_INIT SHALL override the cache set in the same cycle.
REQ-031 Cache-miss latency from grant cycle to done pulse = 5 + init wait + next wait cycles; cache hit = 3 + next wait.
REQ-032 Never assert core_init and core_next in the same cycle; never assert either while in a WAIT state.

Reset
REQ-033 On nrst low: state IDLE, done0/done1/core_init/core_next/key_en/busy = 0, result/core_block/key_rom_addr = 0, cache_valid = 0, pointer = requester 0.
REQ-034 Reset mid-operation SHALL abandon the operation with no done pulse; the first request afterward SHALL miss the cache.

Verification
REQ-035 req0, key_addr0=3, block0=0x00112233445566778899AABBCCDDEEFF after reset -> key_en, core_init, core_next once each, done0 single pulse, result equals the core output, done1 never.
REQ-036 Repeat REQ-035 request with key_addr0=3 -> no key_en, no core_init; core_next only; shorter latency.
REQ-037 req0 and req1 high in the same IDLE cycle after reset -> requester 0 served first, then requester 1; a third simultaneous pair -> requester 0 first again.
REQ-038 Cache loaded with address 3, pulse flush, request address 3 -> key_en and core_init reissued.
REQ-039 nrst low during WAIT_NEXT -> all outputs zero, no done, next request reissues key_en and core_init.

Source files
------------

// File: rtl/aes_arbiter.sv
// Two-requester round-robin front end for an AES encryption core.
// Caches the key ROM address whose expansion is currently loaded in the core so repeat keys skip init.
`timescale 1ns/1ps

module aes_arbiter #(
    parameter int AES_LEN    = 128,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] key_addr0,
    input  logic [ADDR_WIDTH-1:0] key_addr1,
    input  logic [AES_LEN-1:0]    block0,
    input  logic [AES_LEN-1:0]    block1,
    input  logic                  flush,
    output logic                  done0,
    output logic                  done1,
    output logic [AES_LEN-1:0]    result,
    output logic                  busy,
    output logic                  core_init,
    output logic                  core_next,
    input  logic                  core_ready,
    input  logic                  core_valid,
    output logic [AES_LEN-1:0]    core_block,
    input  logic [AES_LEN-1:0]    core_result,
    output logic                  key_en,
    output logic [ADDR_WIDTH-1:0] key_rom_addr
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_KEY_RD    = 3'd1,
        S_INIT      = 3'd2,
        S_WAIT_INIT = 3'd3,
        S_NEXT      = 3'd4,
        S_WAIT_NEXT = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t                r_state;
    logic                  r_owner;
    logic                  r_ptr;
    logic                  r_cache_valid;
    logic [ADDR_WIDTH-1:0] r_cached_addr;
    logic                  r_done0;
    logic                  r_done1;
    logic [AES_LEN-1:0]    r_result;
    logic                  r_busy;
    logic                  r_core_init;
    logic                  r_core_next;
    logic [AES_LEN-1:0]    r_core_block;
    logic                  r_key_en;
    logic [ADDR_WIDTH-1:0] r_key_rom_addr;

    logic                  w_any_req;
    logic                  w_grant;
    logic [ADDR_WIDTH-1:0] w_grant_addr;
    logic [AES_LEN-1:0]    w_grant_block;
    logic                  w_hit;

    // The pointer only breaks ties; a lone request is granted whatever the pointer says.
    assign w_any_req     = req0 | req1;
    assign w_grant       = (req0 & req1) ? r_ptr : req1;
    assign w_grant_addr  = w_grant ? key_addr1 : key_addr0;
    assign w_grant_block = w_grant ? block1 : block0;
    assign w_hit         = r_cache_valid & (w_grant_addr == r_cached_addr);

    assign done0        = r_done0;
    assign done1        = r_done1;
    assign result       = r_result;
    assign busy         = r_busy;
    assign core_init    = r_core_init;
    assign core_next    = r_core_next;
    assign core_block   = r_core_block;
    assign key_en       = r_key_en;
    assign key_rom_addr = r_key_rom_addr;

    // Control FSM; every output is a flop set on the edge that enters the state it belongs to.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= S_IDLE;
            r_owner        <= 1'b0;
            r_ptr          <= 1'b0;
            r_cache_valid  <= 1'b0;
            r_cached_addr  <= {ADDR_WIDTH{1'b0}};
            r_done0        <= 1'b0;
            r_done1        <= 1'b0;
            r_result       <= {AES_LEN{1'b0}};
            r_busy         <= 1'b0;
            r_core_init    <= 1'b0;
            r_core_next    <= 1'b0;
            r_core_block   <= {AES_LEN{1'b0}};
            r_key_en       <= 1'b0;
            r_key_rom_addr <= {ADDR_WIDTH{1'b0}};
        end else begin
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_core_init <= 1'b0;
            r_core_next <= 1'b0;
            r_key_en    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner        <= w_grant;
                        r_core_block   <= w_grant_block;
                        r_key_rom_addr <= w_grant_addr;
                        r_busy         <= 1'b1;
                        if (w_hit) begin
                            r_state     <= S_NEXT;
                            r_core_next <= 1'b1;
                        end else begin
                            r_state  <= S_KEY_RD;
                            r_key_en <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_KEY_RD: begin
                    r_state     <= S_INIT;
                    r_core_init <= 1'b1;
                end
                S_INIT: begin
                    r_state <= S_WAIT_INIT;
                end
                S_WAIT_INIT: begin
                    if (core_ready) begin
                        r_cache_valid <= 1'b1;
                        r_cached_addr <= r_key_rom_addr;
                        r_state       <= S_NEXT;
                        r_core_next   <= 1'b1;
                    end else begin
                        r_state <= S_WAIT_INIT;
                    end
                end
                S_NEXT: begin
                    r_state <= S_WAIT_NEXT;
                end
                S_WAIT_NEXT: begin
                    if (core_ready && core_valid) begin
                        r_result <= core_result;
                        r_done0  <= ~r_owner;
                        r_done1  <= r_owner;
                        r_state  <= S_DONE;
                    end else begin
                        r_state <= S_WAIT_NEXT;
                    end
                end
                S_DONE: begin
                    r_ptr   <= ~r_owner;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
            // Placed last so a flush beats the cache fill in WAIT_INIT on the same edge.
            if (flush) begin
                r_cache_valid <= 1'b0;
            end else begin
                r_cache_valid <= r_cache_valid | ((r_state == S_WAIT_INIT) & core_ready);
            end
        end
    end

endmodule
